fifo_reader: RTL

FIFO_READER -- requirements
Module: fifo_reader

---
 rtl/fifo_reader_if.sv | 23 ++
 rtl/fifo_reader.sv | 52 +++++
 2 files changed

// File: rtl/fifo_reader_if.sv
// fifo_reader_if: FIFO read port and output stream handshake bundle for fifo_reader
interface fifo_reader_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] i_fifo_rdata;
   logic             i_fifo_empty;
   logic             o_fifo_pop;
   logic             o_valid;
   logic             i_ready;
   logic [WIDTH-1:0] o_data;
   logic             o_last;
   logic [1:0]       o_level;

   modport master (
      input  i_fifo_rdata, i_fifo_empty, i_ready,
      output o_fifo_pop, o_valid, o_data, o_last, o_level
   );

   modport slave (
      output i_fifo_rdata, i_fifo_empty, i_ready,
      input  o_fifo_pop, o_valid, o_data, o_last, o_level
   );
endinterface

// File: rtl/fifo_reader.sv
// fifo_reader: drains a show-ahead FIFO into a 2-deep skid-buffered stream with burst framing
module fifo_reader #(
   parameter int WIDTH     = 16,
   parameter int BURST_LEN = 4
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_flush,
   fifo_reader_if.master bus
);
   localparam logic [15:0] LAST_BEAT = 16'(BURST_LEN - 1);

   logic [WIDTH-1:0] head, skid;
   logic [1:0]       level;
   logic [15:0]      beat;
   logic             pop, xfer;

   // pop only looks at our own level so the FIFO side never waits on downstream ready
   always_comb begin
      pop  = i_rst_n && !bus.i_fifo_empty && !i_flush && (level != 2'd2);
      xfer = (level != 2'd0) && bus.i_ready;
   end

   assign bus.o_fifo_pop = pop;
   assign bus.o_valid    = (level != 2'd0);
   assign bus.o_data     = head;
   assign bus.o_last     = (level != 2'd0) && (beat == LAST_BEAT);
   assign bus.o_level    = level;

   // head/skid buffer, occupancy and beat counter; a popped word lands in head when head is free or leaving
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         level <= 2'd0;
         beat  <= 16'd0;
         head  <= '0;
         skid  <= '0;
      end else if (i_flush) begin
         level <= 2'd0;
         beat  <= 16'd0;
      end else begin
         level <= level + {1'b0, pop} - {1'b0, xfer};
         if (xfer)
            beat <= (beat == LAST_BEAT) ? 16'd0 : beat + 16'd1;
         if (pop && (level == 2'd0 || xfer))
            head <= bus.i_fifo_rdata;
         else if (xfer)
            head <= skid;
         if (pop && !xfer && level == 2'd1)
            skid <= bus.i_fifo_rdata;
      end
   end
endmodule
